// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : UART transmitter fed by a small word FIFO (valid/ready input).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 4,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          Tx_dv,
  input  logic [DATA_BITS-1:0]          Tx_Byte,
  output logic                          Tx_ready,
  output logic                          Tx_overflow,
  output logic                          Tx_serial,
  output logic                          Tx_active,
  output logic                          Tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 wr_en, pop, overflow;

  state_t               state, state_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [IW-1:0]        bit_idx, bit_idx_n;
  logic                 stop_cnt, stop_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_bit, par_bit_n;
  logic                 serial, serial_n;
  logic                 done, done_n;
  logic [DATA_BITS-1:0] head;
  logic                 bit_end;

  // Ready comes from the registered count, so a same-cycle pop never frees a slot early.
  assign Tx_ready    = (count != FULL);
  assign wr_en       = Tx_dv & Tx_ready;
  assign head        = mem[rd_ptr];
  assign bit_end     = (bit_cnt == BIT_LAST);
  assign Tx_overflow = overflow;
  assign Tx_serial   = serial;
  assign Tx_active   = (state != IDLE);
  assign Tx_done     = done;
  assign fifo_count  = count;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= Tx_Byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= Tx_dv & ~Tx_ready;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      serial   <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      bit_idx  <= bit_idx_n;
      stop_cnt <= stop_cnt_n;
      shift    <= shift_n;
      par_bit  <= par_bit_n;
      serial   <= serial_n;
      done     <= done_n;
    end
  end

  // serial_n is the level for the next cycle, so the line itself stays registered.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    shift_n    = shift;
    par_bit_n  = par_bit;
    serial_n   = serial;
    done_n     = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        serial_n = 1'b1;
        if (count != '0) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = DATA;
          serial_n  = shift[0];
        end else begin
          bit_cnt_n = bit_cnt + BW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          if (bit_idx == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              state_n  = PARITY;
              serial_n = par_bit;
            end else begin
              state_n    = STOP;
              stop_cnt_n = 1'b0;
              serial_n   = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + IW'(1);
            shift_n   = shift >> 1;
            serial_n  = shift[1];
          end
        end else begin
          bit_cnt_n = bit_cnt + BW'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          bit_cnt_n  = '0;
          state_n    = STOP;
          stop_cnt_n = 1'b0;
          serial_n   = 1'b1;
        end else begin
          bit_cnt_n = bit_cnt + BW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          if (stop_cnt == STOP_LAST) begin
            done_n = 1'b1;
            if (count != '0) begin
              pop = 1'b1;
            end else begin
              state_n  = IDLE;
              serial_n = 1'b1;
            end
          end else begin
            stop_cnt_n = 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt + BW'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        serial_n = 1'b1;
      end
    endcase
    // A pop from IDLE or from the last stop bit always launches a new start bit.
    if (pop) begin
      shift_n   = head;
      par_bit_n = (^head) ^ (PARITY_ODD != 0);
      bit_cnt_n = '0;
      state_n   = START;
      serial_n  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, synthesisable UART transmitter with an input byte FIFO. It replaces the fixed single-byte `Tx_dv`/`Tx_Byte` stimulus path. It accepts words on a valid/ready handshake, queues them, and serialises each as a start bit, data bits LSB-first, an optional parity bit and 1 or 2 stop bits. It sits between any byte producer (bench driver or on-chip logic) and the UART line, and drives the receiver under test directly.

## Interface

Parameters:
- CLK_PER_BIT, 4, clock cycles per UART bit (≥2)
- DATA_BITS, 8, data bits per frame (5..9)
- PARITY_EN, 0, 1 = insert parity bit after data
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
- STOP_BITS, 1, number of stop bits (1 or 2)
- FIFO_DEPTH, 4, queue entries (power of 2, ≥2)

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- Tx_dv  input  1  write strobe; the word is accepted on a rising edge when Tx_ready=1
- Tx_Byte  input  DATA_BITS  word to transmit
- Tx_ready  output  1  FIFO not full
- Tx_overflow  output  1  1-cycle pulse: Tx_dv=1 while Tx_ready=0; the word is dropped
- Tx_serial  output  1  UART line, registered, idle high
- Tx_active  output  1  high while a frame is on the line
- Tx_done  output  1  1-cycle pulse at the end of the last stop bit
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current queue occupancy

## Operation

- Reset values (asynchronous, immediate): Tx_serial=1, Tx_ready=1, Tx_overflow=0, Tx_active=0, Tx_done=0, fifo_count=0. The FIFO is emptied, the FSM goes to IDLE, and all counters are cleared.
- FIFO: circular buffer with wrapping read/write pointers.
  - Write when Tx_dv & Tx_ready.
  - Pop when the FSM loads a word.
  - Simultaneous write and pop leaves fifo_count unchanged.
  - Tx_ready = (fifo_count != FIFO_DEPTH), evaluated on the registered count. A pop in the same cycle does not admit a write into a full FIFO.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: Tx_serial=1. If fifo_count>0, pop into the shift register, compute parity, and go to START.
  - START: Tx_serial=0 for CLK_PER_BIT cycles, then go to DATA.
  - DATA: Tx_serial=shift[0] for CLK_PER_BIT cycles per bit, shifting right. After DATA_BITS bits go to PARITY if PARITY_EN, else STOP.
  - PARITY: Tx_serial = ^data XOR PARITY_ODD for CLK_PER_BIT cycles.
  - STOP: Tx_serial=1 for STOP_BITS*CLK_PER_BIT cycles. At the end, pulse Tx_done. If the FIFO is non-empty, pop and go directly to START (back-to-back, no idle bit); otherwise go to IDLE.
- Counters:
  - The bit-time counter counts 0..CLK_PER_BIT-1.
  - The bit index counts 0..DATA_BITS-1.
  - The stop counter counts 0..STOP_BITS-1.
- Tx_active = (state != IDLE).
- Frame length F = CLK_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles.

## Timing

- A word written at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. Tx_serial falls and Tx_active rises after edge N+1.
- The start bit spans edges N+1..N+1+CLK_PER_BIT. Each subsequent bit occupies exactly CLK_PER_BIT cycles.
- Tx_done is high for the one cycle following edge N+1+F.
- Back-to-back frames: the start bit of frame k+1 begins at the same edge Tx_done of frame k asserts. Tx_active stays high across both frames.
- Tx_overflow is asserted in the cycle after the rejected edge. FIFO contents and fifo_count are unaffected.
- Reset asserted mid-frame: the line returns high immediately, the frame is truncated with no Tx_done, and queued words are lost. After release, the FSM waits in IDLE for new writes.
- Tx_Byte is sampled only at the accepting edge. Later changes have no effect on queued words.

## Test plan

- Defaults; write 0xA5 once -> Tx_serial sequence 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles. Tx_done is pulsed 40 cycles after the start edge. Tx_active is high for exactly 40 cycles.
- Defaults; write 0x11, 0x22, 0x33 on consecutive edges -> three frames with no idle gap. Tx_active is high for 120 cycles, with 3 Tx_done pulses 40 cycles apart. Payloads are received in order.
- Defaults; Tx_dv held high for 6 consecutive edges with distinct words -> 5 words accepted (first popped at edge 1) and fifo_count peaks at 4. Tx_ready drops, 6th word is dropped with one Tx_overflow pulse, and 5 frames are transmitted.
- PARITY_EN=1, PARITY_ODD=1, write 0x03 -> parity bit=1, frame is 44 cycles. With PARITY_ODD=0 -> parity bit=0.
- STOP_BITS=2, DATA_BITS=7, write 0x7F -> 7 ones and a high line for 8 cycles after the data bits; Tx_done occurs at 40 cycles.
- Assert rst_n low 10 cycles into a frame with 2 words queued -> Tx_serial=1 and fifo_count=0 immediately, no Tx_done. After release, one new write produces a clean 40-cycle frame.
